// File: rtl/action_executor.sv
// Action stage after the exact-match lookup: rewrites the destination MAC, picks the
// egress port, decrements the IPv4 TTL and patches the header checksum incrementally.
`ifndef BYTE_BUS
  `define BYTE_BUS 8
`endif
`ifndef MAX_VAL_LEN
  `define MAX_VAL_LEN 8
`endif
`ifndef HDR_MAX_LEN
  `define HDR_MAX_LEN 64
`endif
`ifndef DATA_BUS
  `define DATA_BUS 8
`endif
`ifndef NUM_HEADERS
  `define NUM_HEADERS 4
`endif

module action_executor #(
  parameter int          ETH_HDR_ID   = 0,
  parameter int          IP_HDR_ID    = 1,
  parameter logic [15:0] DEFAULT_PORT = 16'hFFFF,
  parameter bit          MISS_DROP    = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic                                 is_match_i,
  input  logic [`BYTE_BUS*`MAX_VAL_LEN-1:0]    flow_val_i,
  input  logic [`BYTE_BUS*`HDR_MAX_LEN-1:0]    pkt_hdr_i,
  input  logic [`DATA_BUS*`NUM_HEADERS-1:0]    parsed_hdrs_i,
  output logic                                 ready_o,
  output logic                                 drop_o,
  output logic [15:0]                          egress_port_o,
  output logic [`BYTE_BUS*`HDR_MAX_LEN-1:0]    pkt_hdr_o
);

  localparam int HDR_LEN = `HDR_MAX_LEN;
  localparam int HW      = `BYTE_BUS * `HDR_MAX_LEN;
  localparam int FW      = `BYTE_BUS * `MAX_VAL_LEN;
  localparam int OW      = `DATA_BUS;

  typedef enum logic [1:0] {IDLE, REWRITE, CSUM, DONE} state_e;

  state_e          state_q;
  logic [HW-1:0]   hdr_q;
  logic [FW-1:0]   flow_q;
  logic            match_q;
  logic [OW-1:0]   eth_off_q;
  logic [OW-1:0]   ip_off_q;
  logic [17:0]     sum_q;
  logic            csum_en_q;
  logic            drop_q;
  logic [15:0]     port_q;

  // Offsets of the header fields this stage touches, widened so "+13" cannot wrap.
  logic [31:0] eth_idx, ip_idx;
  logic        eth_ok, ip_ok, is_ip, ttl_expired;
  logic [15:0] ethertype, hc, m_old, m_new;
  logic [7:0]  ttl, proto;

  assign eth_idx = 32'(eth_off_q);
  assign ip_idx  = 32'(ip_off_q);
  assign eth_ok  = (eth_idx + 32'd13) < 32'(HDR_LEN);
  assign ip_ok   = (ip_idx + 32'd11) < 32'(HDR_LEN);

  assign ethertype = eth_ok ? {hdr_q[(eth_idx+32'd12)*8 +: 8], hdr_q[(eth_idx+32'd13)*8 +: 8]} : 16'h0;
  assign ttl       = ip_ok ? hdr_q[(ip_idx+32'd8)*8 +: 8] : 8'h0;
  assign proto     = ip_ok ? hdr_q[(ip_idx+32'd9)*8 +: 8] : 8'h0;
  assign hc        = ip_ok ? {hdr_q[(ip_idx+32'd10)*8 +: 8], hdr_q[(ip_idx+32'd11)*8 +: 8]} : 16'h0;

  assign is_ip       = eth_ok && ip_ok && (ethertype == 16'h0800);
  assign ttl_expired = match_q && is_ip && (ttl <= 8'd1);
  assign m_old       = {ttl, proto};
  assign m_new       = {ttl - 8'd1, proto};

  logic [HW-1:0] rw_hdr_d;
  logic          rw_drop_d;
  logic [15:0]   rw_port_d;
  logic [17:0]   rw_sum_d;
  logic          rw_csum_d;

  // NOTE: every output of a combinational block gets a default up front so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rw_hdr_d  = hdr_q;
    rw_drop_d = 1'b0;
    rw_port_d = 16'h0;
    rw_sum_d  = 18'h0;
    rw_csum_d = 1'b0;
    if (!match_q) begin
      rw_drop_d = MISS_DROP;
      rw_port_d = MISS_DROP ? 16'h0 : DEFAULT_PORT;
    end else if (ttl_expired) begin
      rw_drop_d = 1'b1;
    end else begin
      rw_port_d = {flow_q[6*8 +: 8], flow_q[7*8 +: 8]};
      if (eth_ok) begin
        for (int i = 0; i < 6; i++) begin
          rw_hdr_d[(eth_idx + 32'(i))*8 +: 8] = flow_q[i*8 +: 8];
        end
      end
      if (is_ip) begin
        rw_hdr_d[(ip_idx+32'd8)*8 +: 8] = ttl - 8'd1;
        // RFC 1624 eqn. 3: HC' = ~(~HC + ~M + M'); folding happens next cycle.
        rw_sum_d  = {2'b00, ~hc} + {2'b00, ~m_old} + {2'b00, m_new};
        rw_csum_d = 1'b1;
      end
    end
  end

  logic [16:0] fold1;
  logic [15:0] fold2, hc_new;

  assign fold1  = {1'b0, sum_q[15:0]} + 17'(sum_q[17:16]);
  assign fold2  = fold1[15:0] + 16'(fold1[16]);
  assign hc_new = ~fold2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      // NOTE: the header working copy is a plain register, so it is cleared on reset
      // like any other state; nothing stale can reach pkt_hdr_o after a reset.
      hdr_q         <= '0;
      flow_q        <= '0;
      match_q       <= 1'b0;
      eth_off_q     <= '0;
      ip_off_q      <= '0;
      sum_q         <= '0;
      csum_en_q     <= 1'b0;
      drop_q        <= 1'b0;
      port_q        <= '0;
      ready_o       <= 1'b0;
      drop_o        <= 1'b0;
      egress_port_o <= '0;
      pkt_hdr_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            hdr_q     <= pkt_hdr_i;
            flow_q    <= flow_val_i;
            match_q   <= is_match_i;
            eth_off_q <= parsed_hdrs_i[ETH_HDR_ID*OW +: OW];
            ip_off_q  <= parsed_hdrs_i[IP_HDR_ID*OW +: OW];
            state_q   <= REWRITE;
          end
        end
        REWRITE: begin
          hdr_q     <= rw_hdr_d;
          drop_q    <= rw_drop_d;
          port_q    <= rw_port_d;
          sum_q     <= rw_sum_d;
          csum_en_q <= rw_csum_d;
          state_q   <= CSUM;
        end
        CSUM: begin
          if (csum_en_q) begin
            hdr_q[(ip_idx+32'd10)*8 +: 8] <= hc_new[15:8];
            hdr_q[(ip_idx+32'd11)*8 +: 8] <= hc_new[7:0];
          end
          state_q <= DONE;
        end
        DONE: begin
          ready_o       <= 1'b1;
          drop_o        <= drop_q;
          egress_port_o <= port_q;
          pkt_hdr_o     <= hdr_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_parsed;
  assign unused_parsed = ^{1'b0, parsed_hdrs_i};

endmodule
